mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles, legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_wr  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 word, 01 half, 10 byte, 11 reserved.
REQ-007 req_signed  input  1  1 = sign-extend sub-word load, 0 = zero-extend.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 req_ready  output  1  unit idle and accepting.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned or reserved-size access, valid with rsp_valid.
REQ-014 mem_addr  output  32  word-aligned address, bits [1:0] always 00.
REQ-015 mem_wr  output  1  memory write strobe.
REQ-016 mem_wdata  output  32  full word to memory.
REQ-017 mem_rdata  input  32  memory read word, valid MEM_LAT cycles after its address is presented.

Function
REQ-018 Byte order is big-endian: byte offset 0 occupies bits [31:24]; a half at offset 0 occupies bits [31:16].
REQ-019 A request is accepted on an edge where req_valid and req_ready are both high; all req_* fields are registered at that edge.
REQ-020 req_valid is ignored while req_ready is low.
REQ-021 The FSM has states IDLE, RD, WR and RESP; req_ready is high only in IDLE.
REQ-022 Load: IDLE->RD, held MEM_LAT cycles via a down-counter; mem_rdata is captured on the last RD edge; then RD->RESP.
REQ-023 Word store: IDLE->WR, with mem_wr high for exactly one cycle; then WR->RESP.
REQ-024 Sub-word store: IDLE->RD (read the old word)->WR (write the merged word, other bytes unchanged)->RESP.
REQ-025 RESP lasts one cycle with rsp_valid high, then returns to IDLE.
REQ-026 Latency from the accept edge to rsp_valid high is MEM_LAT+1 cycles for a load, 2 for a word store, MEM_LAT+2 for a sub-word store, and 1 for an error.
REQ-027 mem_addr = {addr_q[31:2],2'b00} in RD and WR, and 0 in IDLE and RESP.
REQ-028 mem_wr is decoded from the state register only, with no combinational path from req_*.
REQ-029 Back-to-back: a new request can be accepted on the edge immediately after the RESP cycle.

Reset
REQ-030 reset_n low forces IDLE immediately, even mid-operation; no write completes and no response is issued.
REQ-031 During and after reset: req_ready=1; rsp_valid, rsp_err and mem_wr are 0; rsp_rdata, mem_addr and mem_wdata are 0.

Configuration
REQ-032 With MAU_ALIGN_CHECK_EN defined, any of the following goes IDLE->RESP with rsp_err=1 and performs no memory access: half with addr[0]=1, word with addr[1:0]!=00, or size 11.
REQ-033 Without MAU_ALIGN_CHECK_EN, rsp_err is tied 0, misaligned low address bits are truncated to natural alignment, and size 11 is treated as word.

Structure
REQ-034 Package mau_pkg holds: the size encodings, the FSM state enum, the MEM_LAT bounds, and the byte-lane constants.
REQ-035 Sub-module mau_lane_align (combinational) performs load lane extraction and extension, and store lane merge; the FSM and registers stay in mem_access_unit.

Verification
REQ-036 MEM_LAT=1, memory word 0x100=0x8899AABB; load byte, signed, addr 0x101 -> rsp_rdata=0xFFFFFF99 exactly 2 cycles after accept.
REQ-037 Same word; load half, unsigned, addr 0x102 -> rsp_rdata=0x0000AABB.
REQ-038 Store byte 0x5A to addr 0x103 -> one mem_wr pulse with mem_wdata=0x8899AA5A; rsp_valid 3 cycles after accept.
REQ-039 With MAU_ALIGN_CHECK_EN, load word addr 0x102 -> rsp_err=1, rsp_valid 1 cycle after accept, mem_wr never high.
REQ-040 MEM_LAT=3, word store accepted, reset_n pulsed low in the WR cycle -> mem_wr falls immediately, memory unchanged, req_ready=1 and no rsp_valid.
REQ-041 Two back-to-back word loads (0x100, 0x104) with req_valid held high -> second accepted on the edge after the first RESP; two rsp_valid pulses, correct data, in order.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states,
// latency bounds and big-endian byte-lane helpers.
package mau_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } mau_state_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

  // Big-endian: byte offset k sits at bits [31-8k -: 8], so the right-shift that
  // brings the lane holding the last byte of an access down to bit 0 is (3-k)*8.
  function automatic logic [4:0] lane_shift(input logic [1:0] last_off);
    return {~last_off, 3'b000};
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: extracts and extends sub-word load data and
// merges sub-word store data into the previously read memory word.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] store_data,
  input  logic [31:0] old_word,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [1:0]  last_off;
  logic [31:0] size_mask;
  logic [4:0]  shift;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  // Low offset bits beyond natural alignment are dropped here, which gives the
  // truncation behaviour when alignment checking is not built in.
  always_comb begin
    last_off  = 2'b11;
    size_mask = WORD_MASK;
    case (size)
      SIZE_BYTE: begin
        last_off  = offset;
        size_mask = BYTE_MASK;
      end
      SIZE_HALF: begin
        last_off  = {offset[1], 1'b1};
        size_mask = HALF_MASK;
      end
      default: begin
        last_off  = 2'b11;
        size_mask = WORD_MASK;
      end
    endcase

    shift   = lane_shift(last_off);
    shifted = load_word >> shift;

    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase

    lane_mask  = size_mask << shift;
    store_word = (old_word & ~lane_mask) | ((store_data & size_mask) << shift);
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit with big-endian sub-word support and read-modify-write
// for sub-word stores. Define MAU_ALIGN_CHECK_EN to report misaligned/reserved accesses.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                           (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [1:0] CNT_INIT = 2'(LAT_EFF - 1);

  mau_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic [1:0]  size_norm;
  logic        bad_req;
  logic [31:0] load_data;
  logic [31:0] store_word;

  always_comb begin
    size_norm = (req_size == SIZE_RSVD) ? SIZE_WORD : req_size;
`ifdef MAU_ALIGN_CHECK_EN
    bad_req = (req_size == SIZE_RSVD) ||
              ((req_size == SIZE_HALF) && req_addr[0]) ||
              ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    bad_req = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wr_d     = wr_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = size_norm;
          wr_d     = req_wr;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          cnt_d    = CNT_INIT;
          word_d   = '0;
          err_d    = bad_req;
          if (bad_req) begin
            state_d = ST_RESP;
          end else if (req_wr && (size_norm == SIZE_WORD)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      // Sub-word stores also pass through RD to fetch the word they merge into.
      ST_RD: begin
        if (cnt_q == 2'd0) begin
          word_d  = mem_rdata;
          state_d = wr_q ? ST_WR : ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= SIZE_WORD;
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      err_q    <= err_d;
    end
  end

  mau_lane_align u_lane_align (
    .size       (size_q),
    .sign_ext   (signed_q),
    .offset     (addr_q[1:0]),
    .load_word  (word_q),
    .store_data (wdata_q),
    .old_word   (word_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // All memory-side outputs decode from registered state only.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    mem_wr    = (state_q == ST_WR);
    mem_addr  = ((state_q == ST_RD) || (state_q == ST_WR)) ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata = (state_q == ST_WR) ? store_word : '0;
`ifdef MAU_ALIGN_CHECK_EN
    rsp_err   = (state_q == ST_RESP) && err_q;
    rsp_rdata = ((state_q == ST_RESP) && !wr_q && !err_q) ? load_data : '0;
`else
    rsp_err   = 1'b0;
    rsp_rdata = ((state_q == ST_RESP) && !wr_q && !err_q) ? load_data : '0;
`endif
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: instance A (MEM_LAT=1) runs the
// load/store vectors, instance B (MEM_LAT=3) exercises reset during a write.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_a, req_valid_a, req_wr_a, req_signed_a;
  logic [1:0]  req_size_a;
  logic [31:0] req_addr_a, req_wdata_a;
  logic        req_ready_a, rsp_valid_a, rsp_err_a, mem_wr_a;
  logic [31:0] rsp_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

  logic        reset_n_b, req_valid_b, req_wr_b, req_signed_b;
  logic [1:0]  req_size_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, mem_wr_b;
  logic [31:0] rsp_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_access_unit #(.MEM_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n_a), .req_valid(req_valid_a), .req_wr(req_wr_a),
    .req_size(req_size_a), .req_signed(req_signed_a), .req_addr(req_addr_a),
    .req_wdata(req_wdata_a), .req_ready(req_ready_a), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .mem_addr(mem_addr_a),
    .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  mem_access_unit #(.MEM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .req_valid(req_valid_b), .req_wr(req_wr_b),
    .req_size(req_size_b), .req_signed(req_signed_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .mem_addr(mem_addr_b),
    .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Memory models: A reads combinationally (latency 1), B delays its address by two flops (latency 3).
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] addr_b_d1, addr_b_d2;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int rsp_cnt_b = 0;

  assign mem_rdata_a = mem_a[mem_addr_a[9:2]];
  assign mem_rdata_b = mem_b[addr_b_d2[9:2]];

  always @(posedge clk) begin
    addr_b_d1 <= mem_addr_b;
    addr_b_d2 <= addr_b_d1;
    if (mem_wr_a) begin
      mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
      wr_cnt_a = wr_cnt_a + 1;
    end
    if (mem_wr_b) begin
      mem_b[mem_addr_b[9:2]] <= mem_wdata_b;
      wr_cnt_b = wr_cnt_b + 1;
    end
  end

  int n_checks = 0;
  int n_fails = 0;
  int cyc = 0;
  int next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: every response from A is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (rsp_valid_a) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid with rdata %h, expected no response", rsp_rdata_a);
      end else begin
        mon_e = sb.pop_front();
        checkOutput($sformatf("rsp%0d_rdata", mon_e.id), rsp_rdata_a, mon_e.rdata);
        checkOutput($sformatf("rsp%0d_err", mon_e.id), {31'd0, rsp_err_a}, {31'd0, mon_e.err});
        checkOutput($sformatf("rsp%0d_cycle", mon_e.id), 32'(cyc), 32'(mon_e.due));
      end
    end
    if (rsp_valid_b) rsp_cnt_b++;
  end

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int lat, input bit hold, output int acc);
    int waited;
    exp_t e;
    @(negedge clk);
    req_valid_a  = 1'b1;
    req_wr_a     = wr;
    req_size_a   = size;
    req_signed_a = sgn;
    req_addr_a   = addr;
    req_wdata_a  = wdata;
    waited = 0;
    while (!req_ready_a && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    acc = -1;
    if (!req_ready_a) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL accept_timeout: got req_ready 0 after 50 cycles, expected 1");
      req_valid_a = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = acc + lat - 1;
      e.id    = next_id;
      next_id++;
      sb.push_back(e);
      if (!hold) req_valid_a = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready_a}, 32'd1);
    checkOutput({tag, "_rsp_valid"}, {31'd0, rsp_valid_a}, 32'd0);
    checkOutput({tag, "_rsp_err"}, {31'd0, rsp_err_a}, 32'd0);
    checkOutput({tag, "_mem_wr"}, {31'd0, mem_wr_a}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata_a, 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr_a, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata_a, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc1, acc2, w0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    mem_a[64] = 32'h8899AABB;
    mem_a[65] = 32'h11223344;
    mem_b[64] = 32'h8899AABB;
    reset_n_a = 1'b0; req_valid_a = 1'b0; req_wr_a = 1'b0; req_size_a = 2'b00;
    req_signed_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
    reset_n_b = 1'b0; req_valid_b = 1'b0; req_wr_b = 1'b0; req_size_b = 2'b00;
    req_signed_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;

    repeat (3) @(negedge clk);
    checkResetA("in_reset");
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    @(negedge clk);
    checkResetA("after_reset");

    // Loads from 0x100 = 8899AABB and 0x104 = 11223344.
    applyStimulus(1'b0, SIZE_BYTE, 1'b1, 32'h101, '0, 32'hFFFFFF99, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_HALF, 1'b0, 32'h102, '0, 32'h0000AABB, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_BYTE, 1'b0, 32'h100, '0, 32'h00000088, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_HALF, 1'b1, 32'h100, '0, 32'hFFFF8899, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h104, '0, 32'h11223344, 1'b0, 2, 1'b0, acc1);
    waitDrain();

    // Stores: sub-word read-modify-write, then a plain word write.
    w0 = wr_cnt_a;
    applyStimulus(1'b1, SIZE_BYTE, 1'b0, 32'h103, 32'h0000005A, 32'd0, 1'b0, 3, 1'b0, acc1);
    waitDrain();
    checkOutput("sb_wr_pulses", 32'(wr_cnt_a - w0), 32'd1);
    checkOutput("sb_mem_word", mem_a[64], 32'h8899AA5A);

    w0 = wr_cnt_a;
    applyStimulus(1'b1, SIZE_HALF, 1'b0, 32'h104, 32'h00001234, 32'd0, 1'b0, 3, 1'b0, acc1);
    waitDrain();
    checkOutput("sh_wr_pulses", 32'(wr_cnt_a - w0), 32'd1);
    checkOutput("sh_mem_word", mem_a[65], 32'h12343344);

    w0 = wr_cnt_a;
    applyStimulus(1'b1, SIZE_WORD, 1'b0, 32'h108, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    checkOutput("sw_wr_pulses", 32'(wr_cnt_a - w0), 32'd1);
    checkOutput("sw_mem_word", mem_a[66], 32'hDEADBEEF);

    // Misaligned and reserved-size accesses.
    w0 = wr_cnt_a;
`ifdef MAU_ALIGN_CHECK_EN
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h102, '0, 32'd0, 1'b1, 1, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_HALF, 1'b0, 32'h101, '0, 32'd0, 1'b1, 1, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_RSVD, 1'b0, 32'h104, '0, 32'd0, 1'b1, 1, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b1, SIZE_WORD, 1'b0, 32'h10A, 32'h01020304, 32'd0, 1'b1, 1, 1'b0, acc1);
    waitDrain();
    checkOutput("err_no_mem_wr", 32'(wr_cnt_a - w0), 32'd0);
`else
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h102, '0, 32'h8899AA5A, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_HALF, 1'b0, 32'h101, '0, 32'h00008899, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b0, SIZE_RSVD, 1'b0, 32'h104, '0, 32'h12343344, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    applyStimulus(1'b1, SIZE_WORD, 1'b0, 32'h10A, 32'h01020304, 32'd0, 1'b0, 2, 1'b0, acc1);
    waitDrain();
    checkOutput("trunc_wr_pulses", 32'(wr_cnt_a - w0), 32'd1);
    checkOutput("trunc_mem_word", mem_a[66], 32'h01020304);
`endif

    // Back-to-back loads with req_valid held high throughout.
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h100, '0, 32'h8899AA5A, 1'b0, 2, 1'b1, acc1);
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h104, '0, 32'h12343344, 1'b0, 2, 1'b0, acc2);
    waitDrain();
    checkOutput("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);

    // Instance B: reset pulse while the word store is in WR.
    @(negedge clk);
    req_valid_b = 1'b1;
    req_wr_b    = 1'b1;
    req_size_b  = SIZE_WORD;
    req_addr_b  = 32'h100;
    req_wdata_b = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid_b = 1'b0;
    @(negedge clk);
    checkOutput("rstwr_mem_wr_before", {31'd0, mem_wr_b}, 32'd1);
    #2;
    reset_n_b = 1'b0;
    #1;
    checkOutput("rstwr_mem_wr_after", {31'd0, mem_wr_b}, 32'd0);
    checkOutput("rstwr_req_ready", {31'd0, req_ready_b}, 32'd1);
    checkOutput("rstwr_mem_addr", mem_addr_b, 32'd0);
    @(negedge clk);
    reset_n_b = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rstwr_rsp_count", 32'(rsp_cnt_b), 32'd0);
    checkOutput("rstwr_wr_count", 32'(wr_cnt_b), 32'd0);
    checkOutput("rstwr_mem_word", mem_b[64], 32'h8899AABB);
    checkOutput("rstwr_ready_idle", {31'd0, req_ready_b}, 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
